// File: rtl/lsu.sv
// lsu: load/store unit for the memory stage.
//
// Accepts one memory op from execute (ALU result as effective address),
// runs a single req/ack transaction on the data-memory port, and returns a
// one-cycle completion to writeback carrying load data or an exception cause.
//
// Handshakes:
//   req_*  : a request transfers on a rising edge where req_valid & req_ready.
//            req_ready is high only in IDLE and never depends on req_valid.
//   dmem_* : dmem_req stays high (address/data stable) until the cycle in
//            which dmem_ack is seen; dmem_rdata is valid in that same cycle.
//   rsp_*  : rsp_valid pulses for exactly one cycle; writeback cannot stall.
//
// Ports:
//   clk, n_rst                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake from execute
//   req_addr/wdata/we/size/sgnd/dst  request payload
//   dmem_req/we/addr/be/wdata  memory request (addr word-aligned)
//   dmem_ack/dmem_rdata        memory completion and read word
//   rsp_valid/ld/dst/data/cause  completion to writeback
//   dbg_state                  current FSM state (0 IDLE, 1 ACCESS, 2 RESP)
//
// Byte order is big-endian: byte offset 0 occupies bits [31:24].
module lsu #(
    parameter int ACK_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sgnd,
    input  logic [4:0]  req_dst,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        rsp_valid,
    output logic        rsp_ld,
    output logic [4:0]  rsp_dst,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_cause,
    output logic [1:0]  dbg_state
);

    localparam int CW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   addr_q;
    logic          we_q;
    logic [1:0]    size_q;
    logic          sgnd_q;
    logic [4:0]    dst_q;
    logic [CW-1:0] cnt_q;

    logic          accept;
    logic          misaligned;
    logic          timeout_hit;
    logic [3:0]    store_be;
    logic [31:0]   store_lanes;
    logic [31:0]   rdata_shifted;
    logic [31:0]   load_data;

    assign req_ready = (state_q == IDLE);
    // Combinational from state so reset drops it without waiting for a clock.
    assign dmem_req  = (state_q == ACCESS);
    assign dbg_state = state_q;
    assign accept    = req_valid & req_ready;

    // size 11 is handled exactly like a word access.
    always_comb begin
        misaligned  = 1'b0;
        store_be    = 4'b1111;
        store_lanes = req_wdata;
        case (req_size)
            2'b00: begin
                store_be    = 4'b1000 >> req_addr[1:0];
                store_lanes = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                misaligned  = req_addr[0];
                store_be    = req_addr[1] ? 4'b0011 : 4'b1100;
                store_lanes = {2{req_wdata[15:0]}};
            end
            default: begin
                misaligned  = |req_addr[1:0];
            end
        endcase
    end

    // Shift the addressed byte/half up to the top of the word, then extend.
    always_comb begin
        rdata_shifted = dmem_rdata << {addr_q[1:0], 3'b000};
        case (size_q)
            2'b00:   load_data = {{24{sgnd_q & rdata_shifted[31]}}, rdata_shifted[31:24]};
            2'b01:   load_data = {{16{sgnd_q & rdata_shifted[31]}}, rdata_shifted[31:16]};
            default: load_data = dmem_rdata;
        endcase
    end

    // Fires on the ACK_TIMEOUT-th cycle in ACCESS; an ack in that cycle wins.
    assign timeout_hit = (ACK_TIMEOUT > 0) && (cnt_q == CW'(ACK_TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = misaligned ? RESP : ACCESS;
            end
            ACCESS: begin
                if (dmem_ack || timeout_hit) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            addr_q     <= '0;
            we_q       <= 1'b0;
            size_q     <= '0;
            sgnd_q     <= 1'b0;
            dst_q      <= '0;
            cnt_q      <= '0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            rsp_valid  <= 1'b0;
            rsp_ld     <= 1'b0;
            rsp_dst    <= '0;
            rsp_data   <= '0;
            rsp_cause  <= '0;
        end else begin
            // Response fields are loaded on entry to RESP and cleared after it.
            rsp_valid <= 1'b0;
            rsp_ld    <= 1'b0;
            rsp_dst   <= '0;
            rsp_data  <= '0;
            rsp_cause <= '0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q <= req_addr;
                        we_q   <= req_we;
                        size_q <= req_size;
                        sgnd_q <= req_sgnd;
                        dst_q  <= req_dst;
                        cnt_q  <= '0;
                        if (misaligned) begin
                            rsp_valid <= 1'b1;
                            rsp_data  <= req_addr;
                            rsp_cause <= req_we ? 2'b10 : 2'b01;
                        end else begin
                            dmem_we    <= req_we;
                            dmem_addr  <= {req_addr[31:2], 2'b00};
                            dmem_be    <= req_we ? store_be : 4'b0000;
                            dmem_wdata <= store_lanes;
                        end
                    end
                end
                ACCESS: begin
                    if (dmem_ack || timeout_hit) begin
                        dmem_we    <= 1'b0;
                        dmem_addr  <= '0;
                        dmem_be    <= '0;
                        dmem_wdata <= '0;
                        rsp_valid  <= 1'b1;
                        if (dmem_ack) begin
                            if (!we_q) begin
                                rsp_ld   <= 1'b1;
                                rsp_dst  <= dst_q;
                                rsp_data <= load_data;
                            end
                        end else begin
                            rsp_cause <= 2'b11;
                            rsp_data  <= addr_q;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed bench for lsu built with ACK_TIMEOUT = 4.
// Each op is driven at a falling edge; all outputs are sampled at falling
// edges. Expected completion data is queued when an op is issued and popped
// when its response is observed.
module tb_lsu;

    localparam int TO = 4;

    logic        clk;
    logic        n_rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sgnd;
    logic [4:0]  req_dst;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        rsp_valid;
    logic        rsp_ld;
    logic [4:0]  rsp_dst;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_cause;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    lsu #(.ACK_TIMEOUT(TO)) u_dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_sgnd   (req_sgnd),
        .req_dst    (req_dst),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_ld     (rsp_ld),
        .rsp_dst    (rsp_dst),
        .rsp_data   (rsp_data),
        .rsp_cause  (rsp_cause),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one op starting at the current falling edge (DUT in IDLE) and
    // returns at the falling edge after its response, DUT back in IDLE.
    // delay = cycles in ACCESS before ack; cause 11 means never ack.
    task automatic do_op(input logic we, input logic [1:0] size, input logic sgnd,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] dst, input int delay,
                         input logic [31:0] rdata, input logic hold,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         input logic [1:0] exp_cause, input logic [31:0] exp_data);
        int   n_cycles;
        logic exp_ld;
        logic [31:0] exp_rsp;
        exp_ld = !we && (exp_cause == 2'b00);
        exp_q.push_back(exp_data);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_sgnd  = sgnd;
        req_addr  = addr;
        req_wdata = wdata;
        req_dst   = dst;
        check("ready_idle", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
        if (exp_cause == 2'b01 || exp_cause == 2'b10) begin
            check("misalign_no_req", {31'd0, dmem_req}, 32'd0);
        end else begin
            n_cycles = (exp_cause == 2'b11) ? TO : delay + 1;
            for (int i = 0; i < n_cycles; i++) begin
                check("dmem_req", {31'd0, dmem_req}, 32'd1);
                check("ready_busy", {31'd0, req_ready}, 32'd0);
                check("rsp_quiet", {31'd0, rsp_valid}, 32'd0);
                check("dmem_addr", dmem_addr, {addr[31:2], 2'b00});
                check("dmem_be", {28'd0, dmem_be}, {28'd0, exp_be});
                check("dmem_we", {31'd0, dmem_we}, {31'd0, we});
                if (we) check("dmem_wdata", dmem_wdata, exp_wdata);
                if (exp_cause != 2'b11 && i == delay) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rdata;
                end
                @(negedge clk);
                dmem_ack   = 1'b0;
                dmem_rdata = 32'h0;
            end
            check("req_dropped", {31'd0, dmem_req}, 32'd0);
        end
        // response cycle
        check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("rsp_cause", {30'd0, rsp_cause}, {30'd0, exp_cause});
        check("rsp_ld", {31'd0, rsp_ld}, {31'd0, exp_ld});
        if (exp_ld) check("rsp_dst", {27'd0, rsp_dst}, {27'd0, dst});
        exp_rsp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        check("rsp_data", rsp_data, exp_rsp);
        check("ready_resp", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("rsp_pulse", {31'd0, rsp_valid}, 32'd0);
        check("rsp_data_clr", rsp_data, 32'd0);
        check("ready_back", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        n_rst      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_we     = 1'b0;
        req_size   = '0;
        req_sgnd   = 1'b0;
        req_dst    = '0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);

        // reset state
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        check("rst_dmem_be", {28'd0, dmem_be}, 32'd0);
        check("rst_dmem_addr", dmem_addr, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);

        //     we    size   sg    addr          wdata         dst  dly rdata         hold  be       wdata         cause  data
        do_op(1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 5'd0, 0, 32'h0,        1'b0, 4'b1111, 32'hDEAD_BEEF, 2'b00, 32'h0);
        do_op(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,         5'd5, 0, 32'hDEAD_BEEF, 1'b0, 4'b0000, 32'h0,        2'b00, 32'hDEAD_BEEF);
        do_op(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0,         5'd1, 0, 32'h1234_56F0, 1'b0, 4'b0000, 32'h0,        2'b00, 32'hFFFF_FFF0);
        do_op(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0,         5'd2, 1, 32'h1234_56F0, 1'b0, 4'b0000, 32'h0,        2'b00, 32'h0000_00F0);
        do_op(1'b0, 2'b00, 1'b1, 32'h0000_0100, 32'h0,         5'd3, 0, 32'h1234_56F0, 1'b0, 4'b0000, 32'h0,        2'b00, 32'h0000_0012);
        do_op(1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 5'd0, 0, 32'h0,        1'b0, 4'b0011, 32'hABCD_ABCD, 2'b00, 32'h0);
        do_op(1'b0, 2'b01, 1'b1, 32'h0000_0200, 32'h0,         5'd4, 0, 32'h8001_FFFF, 1'b0, 4'b0000, 32'h0,        2'b00, 32'hFFFF_8001);
        do_op(1'b0, 2'b01, 1'b0, 32'h0000_0202, 32'h0,         5'd6, 0, 32'h8001_FFFF, 1'b0, 4'b0000, 32'h0,        2'b00, 32'h0000_FFFF);
        do_op(1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h1234_5677, 5'd0, 2, 32'h0,        1'b0, 4'b0100, 32'h7777_7777, 2'b00, 32'h0);
        // misaligned
        do_op(1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0,         5'd8, 0, 32'h0,        1'b0, 4'b0000, 32'h0,        2'b01, 32'h0000_0101);
        do_op(1'b1, 2'b01, 1'b0, 32'h0000_0203, 32'h0000_1111, 5'd0, 0, 32'h0,        1'b0, 4'b0000, 32'h0,        2'b10, 32'h0000_0203);
        do_op(1'b0, 2'b11, 1'b1, 32'h0000_0302, 32'h0,         5'd9, 0, 32'h0,        1'b0, 4'b0000, 32'h0,        2'b01, 32'h0000_0302);
        // size 11 acts as word; sgnd ignored for word loads
        do_op(1'b0, 2'b11, 1'b1, 32'h0000_0300, 32'h0,         5'd9, 0, 32'hCAFE_F00D, 1'b0, 4'b0000, 32'h0,        2'b00, 32'hCAFE_F00D);
        // wait states with req_valid held; ack lands on the last allowed cycle
        do_op(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0,         5'd7, 3, 32'h1122_3344, 1'b1, 4'b0000, 32'h0,        2'b00, 32'h1122_3344);
        // follow-up accepted right after RESP
        do_op(1'b1, 2'b10, 1'b0, 32'h0000_0404, 32'h0000_0055, 5'd0, 1, 32'h0,        1'b0, 4'b1111, 32'h0000_0055, 2'b00, 32'h0);
        // bus timeout
        do_op(1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0,         5'd3, 0, 32'h0,        1'b0, 4'b0000, 32'h0,        2'b11, 32'h0000_0500);

        // reset in the middle of ACCESS
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'b10;
        req_addr  = 32'h0000_0600;
        req_dst   = 5'd10;
        @(negedge clk);
        req_valid = 1'b0;
        check("pre_rst_req", {31'd0, dmem_req}, 32'd1);
        @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        check("async_req_drop", {31'd0, dmem_req}, 32'd0);
        check("async_ready", {31'd0, req_ready}, 32'd1);
        check("async_rsp", {31'd0, rsp_valid}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        n_rst = 1'b1;
        @(negedge clk);
        check("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);
        check("post_rst_req", {31'd0, dmem_req}, 32'd0);
        // recovers normally after reset
        do_op(1'b0, 2'b00, 1'b0, 32'h0000_0601, 32'h0,         5'd11, 0, 32'h00AB_0000, 1'b0, 4'b0000, 32'h0,       2'b00, 32'h0000_00AB);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit in the memory stage, directly downstream of the execute-stage ALU.
- Takes the ALU result as the effective address, plus the store data and access attributes, and runs one data-memory transaction through a req/ack handshake.
- Aligns store bytes to lanes and extracts and extends load data.
- Returns a single-cycle completion, carrying load data or an exception cause, to writeback.

Parameters:
- ACK_TIMEOUT, 0, max cycles to wait in ACCESS for dmem_ack; 0 disables the timeout. Counter width is clog2(ACK_TIMEOUT+1).

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- n_rst  in  1  asynchronous, active-low reset
- req_valid  in  1  exec stage presents a memory op
- req_ready  out  1  LSU can accept; a request transfers when req_valid & req_ready
- req_addr  in  32  effective address (ALU res)
- req_wdata  in  32  store source (rt)
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal and treated as word
- req_sgnd  in  1  loads: 1 = sign-extend, 0 = zero-extend
- req_dst  in  5  load destination register
- dmem_req  out  1  memory transaction active
- dmem_we  out  1  write strobe
- dmem_addr  out  32  word address, bits [1:0] forced to 0
- dmem_be  out  4  byte enables; bit 3 = bits [31:24]
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  memory done; rdata valid in the same cycle
- dmem_rdata  in  32  read word
- rsp_valid  out  1  one-cycle completion pulse
- rsp_ld  out  1  writeback must write rsp_dst
- rsp_dst  out  5  destination register
- rsp_data  out  32  load result, or faulting address on an exception
- rsp_cause  out  2  00 ok, 01 load address error, 10 store address error, 11 bus timeout

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
  - Reset values: all outputs 0 except req_ready = 1.
  - Reset asserted mid-ACCESS: dmem_req drops asynchronously and the transaction is abandoned; no rsp is issued.
- req_ready = (state == IDLE). It is combinational from state and has no dependence on req_valid.
- IDLE, on transfer: latch addr, wdata, we, size, sgnd, dst.
  - Misaligned access (half with addr[0]=1, or word with addr[1:0]!=0): go to RESP with cause 01 (load) or 10 (store). No memory access is made.
  - Otherwise go to ACCESS.
- ACCESS:
  - dmem_req = 1.
  - dmem_we, dmem_addr, dmem_be and dmem_wdata are registered and stay stable until ack.
  - On dmem_ack: capture rdata and go to RESP.
  - If ACK_TIMEOUT > 0 and the cycle count in ACCESS reaches ACK_TIMEOUT without ack: deassert dmem_req, go to RESP with cause 11.
  - Ack on the final timeout cycle wins over the timeout.
- RESP: rsp_valid = 1 for exactly one cycle, then IDLE. Writeback never backpressures.
  - rsp_* are registered and are 0 outside RESP.
- Latency: accept at cycle N; dmem_req at N+1; ack at N+1+k gives rsp_valid at N+2+k. Minimum is 2 cycles accept to rsp. Misaligned access gives rsp at N+1.
- Byte order is big-endian; offset o = addr[1:0].
  - Byte: be = 4'b1000 >> o; wdata = {4{wdata[7:0]}}; load data = rdata[31-8o -: 8].
  - Half: be = 1100 (o=0) or 0011 (o=2); wdata = {2{wdata[15:0]}}; load data = rdata[31-8o -: 16].
  - Word: be = 1111; wdata passes through.
  - Loads extend to 32 bits per sgnd. req_sgnd is ignored for word loads and for stores.
  - dmem_be = 0000 on loads. The memory returns the full word.
- rsp_ld = 1 only for a load that completes with cause 00.
  - Stores with cause 00: rsp_data = 0.
  - Any nonzero cause: rsp_data = latched address and rsp_ld = 0.
- dmem_ack outside ACCESS is ignored.
- req_valid while busy is held off via req_ready = 0; inputs are not sampled.

Test Plan:
- Store then load word:
  - SW addr 0x100, wdata 0xDEADBEEF → dmem be=1111, addr 0x100, wdata 0xDEADBEEF; rsp cause 00, rsp_ld=0.
  - LW 0x100 with rdata 0xDEADBEEF, dst 5 → rsp_data 0xDEADBEEF, rsp_ld=1, rsp_dst=5.
- Byte loads:
  - LB 0x103 with rdata 0x123456F0 → rsp_data 0xFFFFFFF0.
  - LBU same → 0x000000F0.
  - LB 0x100 → 0x00000012.
- Halfword:
  - SH 0x202, wdata 0x0000ABCD → be 0011, dmem_wdata 0xABCDABCD, dmem_addr 0x200.
  - LH 0x200 with rdata 0x8001FFFF → 0xFFFF8001.
- Misaligned:
  - LW 0x101 → no dmem_req; rsp one cycle after accept, cause 01, rsp_data 0x101.
  - SH 0x203 → cause 10.
- Wait states and backpressure: ack delayed 3 cycles with req_valid held high → req_ready low throughout, dmem outputs stable, rsp 1 cycle after ack; next request accepted the cycle after RESP.
- Timeout and reset:
  - ACK_TIMEOUT=4, no ack → dmem_req high exactly 4 cycles, then rsp cause 11.
  - Separate run: n_rst pulled low mid-ACCESS → dmem_req=0 immediately, no rsp_valid, req_ready=1.
